// File: rtl/dt_pass_engine.sv
// Single chamfer distance-transform pass (forward raster or backward raster) over the
// interior of an IMG_W x IMG_H image, updating a synchronous single-port RAM in place.
module dt_pass_engine #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dir,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LAST  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] X_MIN   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] X_MAX   = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] Y_MIN   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] Y_MAX   = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] W_C     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] START_F = ADDR_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0] START_B = ADDR_W'((IMG_H - 2) * IMG_W + IMG_W - 2);
    localparam logic [PIX_W-1:0]  PIX_MAX = {PIX_W{1'b1}};
    localparam logic [PIX_W-1:0]  PIX_ZERO = {PIX_W{1'b0}};

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] x,
                                                  input logic [ADDR_W-1:0] y);
        return y * W_C + x;
    endfunction

    function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v);
        return (v == PIX_MAX) ? PIX_MAX : v + PIX_W'(1);
    endfunction

    function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t             state_q;
    logic [2:0]         k_q;
    logic               dir_q;
    logic [ADDR_W-1:0]  x_q, y_q;
    logic [PIX_W-1:0]   cen_q, n0_q, n1_q, n2_q;
    logic               busy_q, done_q, rd_q, we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [PIX_W-1:0]   wdata_q;

    logic [ADDR_W-1:0]  x_d, y_d, nb_x_s, nb_y_s;
    logic               last_px_s, advance_s;
    logic [PIX_W-1:0]   new_pix_s;

    // Next pixel in scan order, neighbour for the read issued next cycle, and the chamfer minimum.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        last_px_s = 1'b0;
        if (dir_q) begin
            last_px_s = (x_q == X_MIN) && (y_q == Y_MIN);
            if (x_q == X_MIN) begin
                x_d = X_MAX;
                y_d = y_q - ADDR_W'(1);
            end else begin
                x_d = x_q - ADDR_W'(1);
            end
        end else begin
            last_px_s = (x_q == X_MAX) && (y_q == Y_MAX);
            if (x_q == X_MAX) begin
                x_d = X_MIN;
                y_d = y_q + ADDR_W'(1);
            end else begin
                x_d = x_q + ADDR_W'(1);
            end
        end

        nb_x_s = x_q;
        nb_y_s = y_q;
        case ({dir_q, k_q[1:0]})
            3'b000: begin nb_x_s = x_q - ADDR_W'(1); nb_y_s = y_q - ADDR_W'(1); end
            3'b001: begin nb_y_s = y_q - ADDR_W'(1); end
            3'b010: begin nb_x_s = x_q + ADDR_W'(1); nb_y_s = y_q - ADDR_W'(1); end
            3'b011: begin nb_x_s = x_q - ADDR_W'(1); end
            3'b100: begin nb_x_s = x_q + ADDR_W'(1); end
            3'b101: begin nb_x_s = x_q - ADDR_W'(1); nb_y_s = y_q + ADDR_W'(1); end
            3'b110: begin nb_y_s = y_q + ADDR_W'(1); end
            3'b111: begin nb_x_s = x_q + ADDR_W'(1); nb_y_s = y_q + ADDR_W'(1); end
            default: begin nb_x_s = x_q; nb_y_s = y_q; end
        endcase

        // mem_rdata carries n3 while in LAST
        new_pix_s = min2(min2(cen_q, sat_inc(n0_q)),
                         min2(min2(sat_inc(n1_q), sat_inc(n2_q)), sat_inc(mem_rdata)));

        advance_s = (state_q == S_WRITE) ||
                    ((state_q == S_FETCH) && (k_q == 3'd1) && (mem_rdata == PIX_ZERO));
    end

    // Pass sequencer with registered memory-side and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= 3'd0;
            dir_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            cen_q   <= '0;
            n0_q    <= '0;
            n1_q    <= '0;
            n2_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dir_q   <= dir;
                        x_q     <= dir ? X_MAX : X_MIN;
                        y_q     <= dir ? Y_MAX : Y_MIN;
                        addr_q  <= dir ? START_B : START_F;
                        k_q     <= 3'd0;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    case (k_q)
                        3'd1:    cen_q <= mem_rdata;
                        3'd2:    n0_q  <= mem_rdata;
                        3'd3:    n1_q  <= mem_rdata;
                        3'd4:    n2_q  <= mem_rdata;
                        default: ;
                    endcase
                    if (k_q == 3'd4) begin
                        rd_q    <= 1'b0;
                        state_q <= S_LAST;
                    end else begin
                        k_q    <= k_q + 3'd1;
                        addr_q <= addr_of(nb_x_s, nb_y_s);
                    end
                end
                S_LAST: begin
                    we_q    <= 1'b1;
                    addr_q  <= addr_of(x_q, y_q);
                    wdata_q <= new_pix_s;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    we_q <= 1'b0;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    rd_q    <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase

            // Leaving a pixel (written, or skipped because it is zero) overrides the case above.
            if (advance_s) begin
                if (last_px_s) begin
                    rd_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else begin
                    x_q     <= x_d;
                    y_q     <= y_d;
                    k_q     <= 3'd0;
                    addr_q  <= addr_of(x_d, y_d);
                    rd_q    <= 1'b1;
                    state_q <= S_FETCH;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign mem_rd    = rd_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dt_pass_engine.sv
// Randomised self-checking bench for dt_pass_engine: a 5x5 and a 3x3 instance, each with
// its own RAM, checked against an in-place chamfer reference model.
module tb_dt_pass_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start5 = 1'b0, start3 = 1'b0, dir = 1'b0;
    logic       busy5, done5, rd5, we5, busy3, done3, rd3, we3;
    logic [4:0] addr5;
    logic [3:0] addr3;
    logic [7:0] wdata5, wdata3;
    logic [7:0] rdata5 = 8'd0, rdata3 = 8'd0;

    logic [7:0] mem5 [0:24];
    logic [7:0] mem3 [0:8];
    logic       ld_en = 1'b0, ld_sel = 1'b0;
    logic [4:0] ld_a = 5'd0;
    logic [7:0] ld_v = 8'd0;

    int rdq5[$], wa5[$], wv5[$], rdq3[$], wa3[$], wv3[$];
    int overlap = 0;
    int model[];
    int exp_rd[$], exp_wa[$], exp_wv[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dt_pass_engine #(.IMG_W(5), .IMG_H(5), .PIX_W(8), .ADDR_W(5)) u_dut5 (
        .clk(clk), .reset(reset), .start(start5), .dir(dir), .busy(busy5), .done(done5),
        .mem_addr(addr5), .mem_rd(rd5), .mem_we(we5), .mem_wdata(wdata5), .mem_rdata(rdata5));

    dt_pass_engine #(.IMG_W(3), .IMG_H(3), .PIX_W(8), .ADDR_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .dir(dir), .busy(busy3), .done(done3),
        .mem_addr(addr3), .mem_rd(rd3), .mem_we(we3), .mem_wdata(wdata3), .mem_rdata(rdata3));

    // RAMs with one-cycle read latency, a bench load port, and an access log per DUT.
    always @(posedge clk) begin
        if (ld_en && !ld_sel) mem5[ld_a] <= ld_v;
        if (ld_en && ld_sel) mem3[ld_a[3:0]] <= ld_v;
        if (rd5) begin rdata5 <= mem5[addr5]; rdq5.push_back(int'(addr5)); end
        if (we5) begin mem5[addr5] <= wdata5; wa5.push_back(int'(addr5)); wv5.push_back(int'(wdata5)); end
        if (rd3) begin rdata3 <= mem3[addr3]; rdq3.push_back(int'(addr3)); end
        if (we3) begin mem3[addr3] <= wdata3; wa3.push_back(int'(addr3)); wv3.push_back(int'(wdata3)); end
        if ((rd5 && we5) || (rd3 && we3)) overlap <= overlap + 1;
    end

    function automatic int ram_val(input int sz, input int a);
        logic [4:0] a5;
        a5 = a[4:0];
        return (sz == 5) ? int'(mem5[a5]) : int'(mem3[a5[3:0]]);
    endfunction

    // mode 0: border 0 / interior 255; 1: all 255; 2: random incl. zeros; 3: random, interior non-zero
    task automatic load_img(input int sz, input int mode, input int zero_at);
        int v, x, y;
        bit inner;
        for (int a = 0; a < sz * sz; a++) begin
            x = a % sz; y = a / sz;
            inner = (x > 0) && (x < sz - 1) && (y > 0) && (y < sz - 1);
            case (mode)
                0: v = inner ? 255 : 0;
                1: v = 255;
                2: begin v = $urandom_range(0, 12); if (v == 12) v = 255; end
                default: v = inner ? $urandom_range(1, 40) : $urandom_range(0, 40);
            endcase
            if (a == zero_at) v = 0;
            model[a] = v;
            ld_en = 1'b1; ld_sel = (sz == 3); ld_a = a[4:0]; ld_v = v[7:0];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
    endtask

    // In-place chamfer pass over the model image; lists the expected reads, writes and cycles.
    task automatic ref_pass(input int w, input bit d, output int cyc);
        int ox[4], oy[4];
        int xs, ys, a, c, m, v, na;
        exp_rd.delete(); exp_wa.delete(); exp_wv.delete();
        cyc = 0;
        if (!d) begin ox = '{-1, 0, 1, -1}; oy = '{-1, -1, -1, 0}; end
        else    begin ox = '{1, -1, 0, 1};  oy = '{0, 1, 1, 1};    end
        for (int i = 0; i < (w - 2) * (w - 2); i++) begin
            xs = 1 + i % (w - 2); ys = 1 + i / (w - 2);
            if (d) begin xs = w - 1 - xs; ys = w - 1 - ys; end
            a = ys * w + xs;
            c = model[a];
            exp_rd.push_back(a);
            exp_rd.push_back((ys + oy[0]) * w + xs + ox[0]);
            if (c == 0) begin
                cyc += 2;
            end else begin
                m = c;
                for (int n = 0; n < 4; n++) begin
                    na = (ys + oy[n]) * w + xs + ox[n];
                    if (n > 0) exp_rd.push_back(na);
                    v = model[na] + 1;
                    if (v > 255) v = 255;
                    if (v < m) m = v;
                end
                model[a] = m;
                exp_wa.push_back(a); exp_wv.push_back(m);
                cyc += 7;
            end
        end
    endtask

    // Starts a pass in the current IDLE cycle, returns in the IDLE cycle after done.
    task automatic run_pass(input int sz, input bit d, input bit noise, input string tag,
                            output int cyc, output int wb);
        int exp_cyc, rb, ov0, nr, nw;
        bit got;
        ref_pass(sz, d, exp_cyc);
        rb  = (sz == 5) ? rdq5.size() : rdq3.size();
        wb  = (sz == 5) ? wa5.size() : wa3.size();
        ov0 = overlap;
        if (sz == 5) start5 = 1'b1; else start3 = 1'b1;
        dir = d;
        @(posedge clk); #1;
        start5 = 1'b0; start3 = 1'b0;
        checks++;
        if (((sz == 5) ? busy5 : busy3) !== 1'b1) begin
            errors++; $display("FAIL %s busy_rise: got %b want 1", tag, (sz == 5) ? busy5 : busy3);
        end
        cyc = 0; got = 1'b0;
        while (!got && cyc < 500) begin
            if (noise) begin
                if (sz == 5) start5 = 1'($urandom_range(0, 1)); else start3 = 1'($urandom_range(0, 1));
                dir = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
            got = (sz == 5) ? done5 : done3;
        end
        start5 = 1'b0; start3 = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL %s timeout: no done within %0d cycles", tag, cyc); end
        checks++;
        if (cyc != exp_cyc) begin errors++; $display("FAIL %s cycles: got %0d want %0d", tag, cyc, exp_cyc); end
        checks++;
        if (((sz == 5) ? busy5 : busy3) !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got 1 want 0", tag); end
        @(posedge clk); #1;
        checks++;
        if (((sz == 5) ? done5 : done3) !== 1'b0) begin errors++; $display("FAIL %s done_pulse: got 1 want 0", tag); end
        nr = ((sz == 5) ? rdq5.size() : rdq3.size()) - rb;
        nw = ((sz == 5) ? wa5.size() : wa3.size()) - wb;
        checks++;
        if (nr != exp_rd.size()) begin errors++; $display("FAIL %s read_count: got %0d want %0d", tag, nr, exp_rd.size()); end
        for (int i = 0; i < nr && i < exp_rd.size(); i++) begin
            checks++;
            if (((sz == 5) ? rdq5[rb + i] : rdq3[rb + i]) != exp_rd[i]) begin
                errors++;
                $display("FAIL %s read_addr[%0d]: got %0d want %0d", tag, i,
                         (sz == 5) ? rdq5[rb + i] : rdq3[rb + i], exp_rd[i]);
            end
        end
        checks++;
        if (nw != exp_wa.size()) begin errors++; $display("FAIL %s write_count: got %0d want %0d", tag, nw, exp_wa.size()); end
        for (int i = 0; i < nw && i < exp_wa.size(); i++) begin
            checks++;
            if (((sz == 5) ? wa5[wb + i] : wa3[wb + i]) != exp_wa[i] ||
                ((sz == 5) ? wv5[wb + i] : wv3[wb + i]) != exp_wv[i]) begin
                errors++;
                $display("FAIL %s write[%0d]: got addr %0d data %0d want addr %0d data %0d", tag, i,
                         (sz == 5) ? wa5[wb + i] : wa3[wb + i], (sz == 5) ? wv5[wb + i] : wv3[wb + i],
                         exp_wa[i], exp_wv[i]);
            end
        end
        for (int a = 0; a < sz * sz; a++) begin
            checks++;
            if (ram_val(sz, a) != model[a]) begin
                errors++; $display("FAIL %s image[%0d]: got %0d want %0d", tag, a, ram_val(sz, a), model[a]);
            end
        end
        checks++;
        if (overlap != ov0) begin errors++; $display("FAIL %s rd_we_overlap: got %0d want 0", tag, overlap - ov0); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy5, done5, rd5, we5, addr5, wdata5} !== 17'd0) begin
            errors++; $display("FAIL reset_out5: got %h want 0", {busy5, done5, rd5, we5, addr5, wdata5});
        end
        checks++;
        if ({busy3, done3, rd3, we3, addr3, wdata3} !== 16'd0) begin
            errors++; $display("FAIL reset_out3: got %h want 0", {busy3, done3, rd3, we3, addr3, wdata3});
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_forward_border();
        int cyc, wb;
        load_img(5, 0, -1);
        run_pass(5, 1'b0, 1'b0, "fwd_border", cyc, wb);
        checks++;
        if (cyc != 63) begin errors++; $display("FAIL fwd_border_latency: got %0d want 63", cyc); end
        for (int x = 1; x <= 3; x++) begin
            checks++;
            if (ram_val(5, 5 + x) != 1) begin errors++; $display("FAIL fwd_row1[%0d]: got %0d want 1", x, ram_val(5, 5 + x)); end
        end
        checks++;
        if (ram_val(5, 12) != 2) begin errors++; $display("FAIL fwd_centre: got %0d want 2", ram_val(5, 12)); end
    endtask

    // Started in the IDLE cycle right after the forward pass's done.
    task automatic test_back_to_back();
        int cyc, wb, x, y;
        run_pass(5, 1'b1, 1'b0, "bwd_after_fwd", cyc, wb);
        for (int a = 0; a < 25; a++) begin
            x = a % 5; y = a / 5;
            checks++;
            if (ram_val(5, a) != ((a == 12) ? 2 : ((x == 0 || x == 4 || y == 0 || y == 4) ? 0 : 1))) begin
                errors++; $display("FAIL city_block[%0d]: got %0d", a, ram_val(5, a));
            end
        end
        for (int i = wb; i < wa5.size(); i++) begin
            x = wa5[i] % 5; y = wa5[i] / 5;
            checks++;
            if (x == 0 || x == 4 || y == 0 || y == 4) begin errors++; $display("FAIL border_write: got addr %0d want interior", wa5[i]); end
        end
    endtask

    task automatic test_zero_skip();
        int cyc, wb;
        load_img(5, 3, 12);
        run_pass(5, 1'b0, 1'b0, "zero_skip", cyc, wb);
        checks++;
        if (cyc != 58) begin errors++; $display("FAIL zero_skip_cycles: got %0d want 58", cyc); end
        for (int i = wb; i < wa5.size(); i++) begin
            checks++;
            if (wa5[i] == 12) begin errors++; $display("FAIL zero_skip_write: got write at 12 want none"); end
        end
    endtask

    task automatic test_saturation();
        int cyc, wb;
        load_img(5, 1, -1);
        run_pass(5, 1'b0, 1'b0, "saturate", cyc, wb);
        checks++;
        if (wa5.size() - wb != 9) begin errors++; $display("FAIL sat_count: got %0d want 9", wa5.size() - wb); end
        for (int i = wb; i < wv5.size(); i++) begin
            checks++;
            if (wv5[i] != 255) begin errors++; $display("FAIL sat_value: got %0d want 255", wv5[i]); end
        end
    endtask

    task automatic test_start_dir_noise();
        int cyc, wb;
        for (int it = 0; it < 3; it++) begin
            load_img(5, 2, -1);
            run_pass(5, 1'($urandom_range(0, 1)), 1'b1, "noise", cyc, wb);
        end
    endtask

    // Reset is sampled at the edge that would enter WRITE of the second pixel.
    task automatic test_reset_midpass();
        int cyc, wb;
        load_img(5, 0, -1);
        wb = wa5.size();
        start5 = 1'b1; dir = 1'b0;
        @(posedge clk); #1;
        start5 = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy5, done5, rd5, we5, addr5, wdata5} !== 17'd0) begin
            errors++; $display("FAIL midpass_reset_out: got %h want 0", {busy5, done5, rd5, we5, addr5, wdata5});
        end
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (wa5.size() - wb != 1) begin errors++; $display("FAIL midpass_writes: got %0d want 1", wa5.size() - wb); end
        checks++;
        if (ram_val(5, 7) != 255) begin errors++; $display("FAIL midpass_suppressed: got %0d want 255", ram_val(5, 7)); end
        load_img(5, 0, -1);
        run_pass(5, 1'b0, 1'b0, "after_reset", cyc, wb);
    endtask

    task automatic test_3x3();
        int cyc, wb, rb;
        int fwd[5], bwd[5];
        fwd = '{4, 0, 1, 2, 3};
        bwd = '{4, 5, 6, 7, 8};
        for (int d = 0; d < 2; d++) begin
            load_img(3, 3, -1);
            rb = rdq3.size();
            run_pass(3, d[0], 1'b0, "img3x3", cyc, wb);
            checks++;
            if (cyc != 7) begin errors++; $display("FAIL img3x3_cycles dir%0d: got %0d want 7", d, cyc); end
            for (int i = 0; i < 5 && rb + i < rdq3.size(); i++) begin
                checks++;
                if (rdq3[rb + i] != ((d == 0) ? fwd[i] : bwd[i])) begin
                    errors++; $display("FAIL img3x3_addr dir%0d[%0d]: got %0d want %0d", d, i,
                                       rdq3[rb + i], (d == 0) ? fwd[i] : bwd[i]);
                end
            end
            checks++;
            if (wa3.size() - wb != 1 || wa3[wa3.size() - 1] != 4) begin
                errors++; $display("FAIL img3x3_write dir%0d: got %0d writes want 1 at 4", d, wa3.size() - wb);
            end
        end
    endtask

    task automatic test_random();
        int cyc, wb;
        for (int it = 0; it < 8; it++) begin
            load_img(5, 2, -1);
            run_pass(5, 1'b0, 1'b0, "rand_fwd", cyc, wb);
            run_pass(5, 1'b1, 1'b0, "rand_bwd", cyc, wb);
        end
        for (int it = 0; it < 4; it++) begin
            load_img(3, 2, -1);
            run_pass(3, 1'($urandom_range(0, 1)), 1'b0, "rand3", cyc, wb);
        end
    endtask

    initial begin
        model = new[25];
        test_reset();
        test_forward_border();
        test_back_to_back();
        test_zero_skip();
        test_saturation();
        test_start_dir_noise();
        test_reset_midpass();
        test_3x3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
